// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: PC/IMEM handshake, decode control and IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline / memory.
`timescale 1ns/1ps
interface fetch_stage_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] i_addr;
   logic              pc_next;
   logic              imemREN;
   logic [DATA_W-1:0] imemaddr;
   logic              ihit;
   logic [DATA_W-1:0] imemload;
   logic              stall;
   logic              flush;
   logic [DATA_W-1:0] instr;
   logic [DATA_W-1:0] npc;
   logic              if_valid;
   logic              halted;

   modport master (
      input  i_addr, ihit, imemload, stall, flush,
      output pc_next, imemREN, imemaddr, instr, npc, if_valid, halted
   );

   modport slave (
      output i_addr, ihit, imemload, stall, flush,
      input  pc_next, imemREN, imemaddr, instr, npc, if_valid, halted
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues IMEM reads for the current PC, fills the
// IF/ID register, one-entry buffer for hits that arrive while decode stalls.
`timescale 1ns/1ps
module fetch_stage #(
   parameter int                DATA_W   = 32,
   parameter logic [5:0]        HALT_OP  = 6'b111111,
   parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
   input logic           CLK,
   input logic           nRST,
   fetch_stage_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD, HALTED} state_t;

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] instr_reg, instr_next;
   logic [DATA_W-1:0] npc_reg, npc_next;
   logic              valid_reg, valid_next;
   logic              halted_reg, halted_next;
   logic [DATA_W-1:0] buf_instr_reg, buf_instr_next;
   logic [DATA_W-1:0] buf_npc_reg, buf_npc_next;

   logic              pc_adv;
   logic              mem_ren;
   logic [DATA_W-1:0] seq_npc;
   logic              load_is_halt;
   logic              buf_is_halt;

   assign seq_npc      = bus.i_addr + DATA_W'(4);
   assign load_is_halt = (bus.imemload[DATA_W-1 -: 6] == HALT_OP);
   assign buf_is_halt  = (buf_instr_reg[DATA_W-1 -: 6] == HALT_OP);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg     <= IDLE;
         instr_reg     <= NOP_WORD;
         npc_reg       <= '0;
         valid_reg     <= 1'b0;
         halted_reg    <= 1'b0;
         buf_instr_reg <= NOP_WORD;
         buf_npc_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         instr_reg     <= instr_next;
         npc_reg       <= npc_next;
         valid_reg     <= valid_next;
         halted_reg    <= halted_next;
         buf_instr_reg <= buf_instr_next;
         buf_npc_reg   <= buf_npc_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      instr_next     = instr_reg;
      npc_next       = npc_reg;
      valid_next     = valid_reg;
      halted_next    = halted_reg;
      buf_instr_next = buf_instr_reg;
      buf_npc_next   = buf_npc_reg;
      pc_adv         = 1'b0;
      mem_ren        = 1'b0;

      case (state_reg)
         IDLE: begin
            state_next = REQ;
         end

         REQ: begin
            mem_ren = 1'b1;
            // flush outranks any hit, so a squashed fetch never lands in the buffer
            if (bus.flush) begin
               pc_adv     = 1'b1;
               valid_next = 1'b0;
               instr_next = NOP_WORD;
            end else if (bus.ihit && !bus.stall) begin
               pc_adv     = 1'b1;
               instr_next = bus.imemload;
               npc_next   = seq_npc;
               valid_next = 1'b1;
               if (load_is_halt) begin
                  halted_next = 1'b1;
                  state_next  = HALTED;
               end
            end else if (bus.ihit) begin
               buf_instr_next = bus.imemload;
               buf_npc_next   = seq_npc;
               state_next     = HOLD;
            end else if (!bus.stall) begin
               valid_next = 1'b0;
            end
         end

         HOLD: begin
            if (bus.flush) begin
               pc_adv     = 1'b1;
               valid_next = 1'b0;
               instr_next = NOP_WORD;
               state_next = REQ;
            end else if (!bus.stall) begin
               pc_adv     = 1'b1;
               instr_next = buf_instr_reg;
               npc_next   = buf_npc_reg;
               valid_next = 1'b1;
               if (buf_is_halt) begin
                  halted_next = 1'b1;
                  state_next  = HALTED;
               end else begin
                  state_next = REQ;
               end
            end
         end

         HALTED: begin
            // terminal until reset; only lets decode drain the HALT word
            if (!bus.stall) begin
               valid_next = 1'b0;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.pc_next  = pc_adv;
   assign bus.imemREN  = mem_ren;
   assign bus.imemaddr = bus.i_addr;
   assign bus.instr    = valid_reg ? instr_reg : NOP_WORD;
   assign bus.npc      = npc_reg;
   assign bus.if_valid = valid_reg;
   assign bus.halted   = halted_reg;
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_fetch_stage;
   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   fetch_stage_if bus();

   fetch_stage dut (
      .CLK (clk),
      .nRST(nrst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] ins;
      logic [31:0] np;
   } ent_t;

   // model: fetched-but-not-delivered words live in a queue
   ent_t        pend[$];
   logic        m_started, m_halted, m_valid;
   logic [31:0] m_instr, m_npc;
   logic        last_pcn;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %08h exp %08h", tag, got, exp);
      end
   endtask

   function automatic logic is_halt(input logic [31:0] d);
      return d[31:26] == 6'b111111;
   endfunction

   task automatic model_reset();
      m_started = 1'b0;
      m_halted  = 1'b0;
      m_valid   = 1'b0;
      m_instr   = 32'h0;
      m_npc     = 32'h0;
      pend.delete();
   endtask

   task automatic deliver(input logic [31:0] ins, input logic [31:0] np);
      m_instr = ins;
      m_npc   = np;
      m_valid = 1'b1;
      if (is_halt(ins)) m_halted = 1'b1;
   endtask

   task automatic check_regs();
      check_val("instr", bus.instr, m_valid ? m_instr : 32'h0);
      check_val("npc", bus.npc, m_npc);
      check_val("if_valid", 32'(bus.if_valid), 32'(m_valid));
      check_val("halted", 32'(bus.halted), 32'(m_halted));
   endtask

   task automatic cycle(input logic h, input logic s, input logic f,
                        input logic [31:0] a, input logic [31:0] d);
      logic e_ren, e_pcn;
      ent_t e;
      @(negedge clk);
      bus.ihit = h; bus.stall = s; bus.flush = f; bus.i_addr = a; bus.imemload = d;
      #1;
      e_ren = m_started && !m_halted && (pend.size() == 0);
      e_pcn = m_started && !m_halted &&
              (f || ((pend.size() != 0) ? !s : (h && !s)));
      check_val("imemREN", 32'(bus.imemREN), 32'(e_ren));
      check_val("pc_next", 32'(bus.pc_next), 32'(e_pcn));
      check_val("imemaddr", bus.imemaddr, a);
      @(posedge clk);
      if (!m_started) begin
         m_started = 1'b1;
      end else if (m_halted) begin
         if (!s) m_valid = 1'b0;
      end else if (pend.size() != 0) begin
         if (f) begin
            pend.delete();
            m_valid = 1'b0;
         end else if (!s) begin
            e = pend.pop_front();
            deliver(e.ins, e.np);
         end
      end else if (f) begin
         m_valid = 1'b0;
         m_instr = 32'h0;
      end else if (h && !s) begin
         deliver(d, a + 32'd4);
      end else if (h) begin
         e.ins = d;
         e.np  = a + 32'd4;
         pend.push_back(e);
      end else if (!s) begin
         m_valid = 1'b0;
      end
      #1;
      check_regs();
      last_pcn = e_pcn;
      cyc++;
      $display("cyc %0d addr %08h ihit %0b stall %0b flush %0b ld %08h -> pcn %0b ren %0b instr %08h npc %08h v %0b h %0b",
               cyc, a, h, s, f, d, bus.pc_next, bus.imemREN, bus.instr, bus.npc, bus.if_valid, bus.halted);
   endtask

   // reset lands mid-cycle so any in-flight request is abandoned
   task automatic apply_reset();
      @(negedge clk);
      #2 nrst = 1'b0;
      #1 model_reset();
      check_regs();
      check_val("rst_pc_next", 32'(bus.pc_next), 32'h0);
      check_val("rst_imemREN", 32'(bus.imemREN), 32'h0);
      @(posedge clk);
      #2 nrst = 1'b1;
      $display("reset applied");
   endtask

   logic [31:0] tb_pc;
   logic        rh, rs, rf;
   logic [31:0] rd, rv;

   initial begin
      bus.ihit = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
      bus.i_addr = 32'h0; bus.imemload = 32'h0;
      model_reset();
      last_pcn = 1'b0;
      #12;
      apply_reset();

      // straight-line hits, then misses, stall/hold, flushes, wrap, halt
      repeat (3) cycle(1, 0, 0, 32'h0, 32'h20010005);
      check_val("t1_instr", bus.instr, 32'h20010005);
      check_val("t1_npc", bus.npc, 32'h4);
      repeat (3) cycle(0, 0, 0, 32'h40, 32'h12345678);
      cycle(1, 0, 0, 32'h40, 32'h8C220000);
      check_val("t2_instr", bus.instr, 32'h8C220000);
      check_val("t2_npc", bus.npc, 32'h44);
      cycle(1, 1, 0, 32'h44, 32'hAC230004);
      cycle(1, 1, 0, 32'h44, 32'hDEADBEEF);
      check_val("t3_hold_instr", bus.instr, 32'h8C220000);
      cycle(0, 0, 0, 32'h44, 32'h0);
      check_val("t3_instr", bus.instr, 32'hAC230004);
      check_val("t3_npc", bus.npc, 32'h48);
      cycle(1, 1, 1, 32'h48, 32'h11111111);
      check_val("t4_valid", 32'(bus.if_valid), 32'h0);
      check_val("t4_instr", bus.instr, 32'h0);
      cycle(1, 1, 0, 32'h50, 32'h22222222);
      cycle(0, 1, 1, 32'h50, 32'h0);
      check_val("t4_hold_valid", 32'(bus.if_valid), 32'h0);
      cycle(1, 0, 0, 32'hFFFFFFFC, 32'h00000001);
      check_val("t6_npc", bus.npc, 32'h0);
      cycle(1, 0, 0, 32'h0, 32'hFFFFFFFF);
      check_val("t5_instr", bus.instr, 32'hFFFFFFFF);
      check_val("t5_halted", 32'(bus.halted), 32'h1);
      cycle(1, 0, 1, 32'h4, 32'h33333333);
      cycle(1, 0, 1, 32'h8, 32'h33333333);
      check_val("t5_stuck", 32'(bus.halted), 32'h1);
      apply_reset();
      check_val("t5_cleared", 32'(bus.halted), 32'h0);

      tb_pc = 32'h100;
      for (int n = 0; n < 500; n++) begin
         if ((m_halted && ($urandom % 6 == 0)) || ($urandom % 120 == 0)) begin
            apply_reset();
            tb_pc = 32'h0;
         end
         rh = ($urandom % 4) != 0;
         rs = ($urandom % 4) == 0;
         rf = ($urandom % 12) == 0;
         rv = $urandom;
         rd = ($urandom % 40 == 0) ? {6'b111111, rv[25:0]} : rv;
         cycle(rh, rs, rf, tb_pc, rd);
         if (last_pcn) begin
            rv = $urandom;
            if (rf) tb_pc = {rv[31:2], 2'b00};
            else if ($urandom % 40 == 0) tb_pc = 32'hFFFFFFFC;
            else tb_pc = tb_pc + 32'd4;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
